// File: rtl/cc_register_bank.sv
// cc_register_bank: parametrised control/status register file on a simple
// host bus. Each register is read/write, read-only, write-1-to-clear status
// or write-pulse command, selected by parameter masks. Reads return one
// cycle after the request. W1C status bits are ORed into a registered irq.
module cc_register_bank #(
  parameter int                               ADDR_WIDTH   = 4,
  parameter int                               DATA_WIDTH   = 16,
  parameter int                               NUM_REGS     = 16,
  parameter logic [NUM_REGS-1:0]              RW_MASK      = '1,
  parameter logic [NUM_REGS-1:0]              W1C_MASK     = '0,
  parameter logic [NUM_REGS-1:0]              PULSE_MASK   = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0]   RESET_VALUES = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  input  logic                           rd,
  input  logic                           wr,
  input  logic [DATA_WIDTH/8-1:0]        be,
  input  logic [ADDR_WIDTH-1:0]          addr,
  input  logic [DATA_WIDTH-1:0]          data_in,
  output logic [DATA_WIDTH-1:0]          data_out,
  output logic                           rd_valid,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] values_in,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] set_in,
  output logic [NUM_REGS*DATA_WIDTH-1:0] values_out,
  output logic [NUM_REGS-1:0]            write_strobe,
  output logic [DATA_WIDTH-1:0]          pulse_data,
  output logic                           irq
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    REG_RO,
    REG_RW,
    REG_W1C,
    REG_PULSE
  } reg_kind_e;

  // Pulse overrides W1C, which overrides RW; no mask bit means read-only.
  function automatic reg_kind_e kind_of(input int idx);
    if (PULSE_MASK[idx])    return REG_PULSE;
    else if (W1C_MASK[idx]) return REG_W1C;
    else if (RW_MASK[idx])  return REG_RW;
    else                    return REG_RO;
  endfunction

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [DATA_WIDTH-1:0] data_out_q, rd_data_d;
  logic [DATA_WIDTH-1:0] pulse_data_q;
  logic [NUM_REGS-1:0]   strobe_q, strobe_d;
  logic                  rd_valid_q;
  logic                  irq_q, irq_d;

  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] byte_mask;
  logic [NUM_REGS-1:0]   hit;

  // A read wins over a simultaneous write; the write is simply dropped.
  assign rd_acc = en & rd;
  assign wr_acc = en & wr & ~rd;

  // Expand byte enables to a bit mask and decode the address.
  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    byte_mask = '0;
    hit       = '0;
    for (int k = 0; k < NUM_BYTES; k++) begin
      byte_mask[k*8 +: 8] = {8{be[k]}};
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      hit[i] = (addr == ADDR_WIDTH'(i));
    end
  end

  // Next-state of every register, pulse strobes, irq and the read mux.
  always_comb begin
    logic [DATA_WIDTH-1:0] clr;
    clr       = '0;
    irq_d     = 1'b0;
    strobe_d  = '0;
    rd_data_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      clr       = (wr_acc && hit[i]) ? (data_in & byte_mask) : '0;
      case (kind_of(i))
        REG_RW: begin
          if (wr_acc && hit[i]) begin
            regs_d[i] = (regs_q[i] & ~byte_mask) | (data_in & byte_mask);
          end
          if (hit[i]) rd_data_d = regs_q[i];
        end
        REG_W1C: begin
          // Set beats clear when both land on the same bit in one cycle.
          regs_d[i] = (regs_q[i] & ~clr) | set_in[i*DATA_WIDTH +: DATA_WIDTH];
          irq_d     = irq_d | (|regs_d[i]);
          if (hit[i]) rd_data_d = regs_q[i];
        end
        REG_PULSE: begin
          strobe_d[i] = wr_acc && hit[i];
        end
        default: begin
          if (hit[i]) rd_data_d = values_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
      endcase
    end
  end

  // State update: registers, read port, pulse port and irq.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the register array is built from flops, not RAM, so it is
      // reset element by element to its defined power-on image.
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (kind_of(i) == REG_RW) ?
                     RESET_VALUES[i*DATA_WIDTH +: DATA_WIDTH] : '0;
      end
      data_out_q   <= '0;
      rd_valid_q   <= 1'b0;
      strobe_q     <= '0;
      pulse_data_q <= '0;
      irq_q        <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      if (rd_acc) data_out_q <= rd_data_d;
      rd_valid_q <= rd_acc;
      strobe_q   <= strobe_d;
      if (|strobe_d) pulse_data_q <= data_in & byte_mask;
      irq_q      <= irq_d;
    end
  end

  // Export stored contents; RO and pulse slices read as zero.
  always_comb begin
    values_out = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (kind_of(i) == REG_RW || kind_of(i) == REG_W1C) begin
        values_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
      end
    end
  end

  assign data_out     = data_out_q;
  assign rd_valid     = rd_valid_q;
  assign write_strobe = strobe_q;
  assign pulse_data   = pulse_data_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_cc_register_bank.sv
// Directed testbench for cc_register_bank: a vector table of single-cycle
// bus operations with hand-computed results, plus sequences for reset
// during an access and set events on non-status registers.
module tb_cc_register_bank;

  localparam int AW = 4;
  localparam int DW = 16;
  localparam int NR = 12;
  localparam logic [NR-1:0] RW_M    = 12'hFFD;  // reg1 read-only
  localparam logic [NR-1:0] W1C_M   = 12'h020;  // reg5 status
  localparam logic [NR-1:0] PULSE_M = 12'h080;  // reg7 command
  localparam logic [NR*DW-1:0] RST_V =
    ((NR*DW)'(16'h1200) << (3*DW)) | ((NR*DW)'(16'h1234) << (2*DW));

  logic          clk = 1'b0;
  logic          reset;
  logic          en, rd, wr;
  logic [1:0]    be;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_in, data_out, pulse_data;
  logic          rd_valid, irq;
  logic [NR*DW-1:0] values_in, set_in, values_out;
  logic [NR-1:0] write_strobe;

  int total = 0;
  int bad   = 0;

  cc_register_bank #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR),
    .RW_MASK(RW_M), .W1C_MASK(W1C_M), .PULSE_MASK(PULSE_M),
    .RESET_VALUES(RST_V)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .rd(rd), .wr(wr), .be(be),
    .addr(addr), .data_in(data_in), .data_out(data_out),
    .rd_valid(rd_valid), .values_in(values_in), .set_in(set_in),
    .values_out(values_out), .write_strobe(write_strobe),
    .pulse_data(pulse_data), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          en, rd, wr;
    logic [1:0]    be;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] set5;
    logic          e_valid;
    logic [DW-1:0] e_dout;
    logic [NR-1:0] e_strobe;
    logic [DW-1:0] e_pdata;
    logic          e_irq;
  } vec_t;

  vec_t vecs [28];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] vo(input int idx);
    logic [NR*DW-1:0] v;
    v = values_out;
    return v[idx*DW +: DW];
  endfunction

  task automatic idle();
    en = 1'b0; rd = 1'b0; wr = 1'b0; be = 2'b00; addr = '0; data_in = '0;
  endtask

  initial begin
    // reg1 (read-only) returns 0xBEEF; reg0 slice is ignored since reg0 is RW.
    values_in = ((NR*DW)'(16'hBEEF) << DW) | (NR*DW)'(16'hAAAA);
    set_in    = '0;
    idle();
    reset = 1'b1;

    //          en    rd    wr    be     addr   din       set5      v     dout      strobe   pdata     irq
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 2'b11, 4'd2,  16'h0000, 16'h0000, 1'b1, 16'h1234, 12'h000, 16'h0000, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 2'b00, 4'd2,  16'h0000, 16'h0000, 1'b0, 16'h1234, 12'h000, 16'h0000, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 2'b01, 4'd3,  16'hABCD, 16'h0000, 1'b0, 16'h1234, 12'h000, 16'h0000, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 2'b11, 4'd3,  16'h0000, 16'h0000, 1'b1, 16'h12CD, 12'h000, 16'h0000, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 2'b10, 4'd3,  16'hFF00, 16'h0000, 1'b0, 16'h12CD, 12'h000, 16'h0000, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 2'b11, 4'd3,  16'h0000, 16'h0000, 1'b1, 16'hFFCD, 12'h000, 16'h0000, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 2'b00, 4'd0,  16'h0000, 16'h0001, 1'b0, 16'hFFCD, 12'h000, 16'h0000, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 2'b11, 4'd5,  16'h0000, 16'h0000, 1'b1, 16'h0001, 12'h000, 16'h0000, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 2'b11, 4'd5,  16'h0001, 16'h0001, 1'b0, 16'h0001, 12'h000, 16'h0000, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 2'b11, 4'd5,  16'h0000, 16'h0000, 1'b1, 16'h0001, 12'h000, 16'h0000, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 2'b11, 4'd5,  16'h0001, 16'h0000, 1'b0, 16'h0001, 12'h000, 16'h0000, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 2'b11, 4'd5,  16'h0000, 16'h0000, 1'b1, 16'h0000, 12'h000, 16'h0000, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 2'b11, 4'd7,  16'h0042, 16'h0000, 1'b0, 16'h0000, 12'h080, 16'h0042, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 2'b00, 4'd0,  16'h0000, 16'h0000, 1'b0, 16'h0000, 12'h000, 16'h0042, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 2'b01, 4'd7,  16'h1111, 16'h0000, 1'b0, 16'h0000, 12'h080, 16'h0011, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 1'b1, 2'b11, 4'd7,  16'h2233, 16'h0000, 1'b0, 16'h0000, 12'h080, 16'h2233, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 2'b00, 4'd0,  16'h0000, 16'h0000, 1'b0, 16'h0000, 12'h000, 16'h2233, 1'b0};
    vecs[17] = '{1'b1, 1'b1, 1'b0, 2'b11, 4'd7,  16'h0000, 16'h0000, 1'b1, 16'h0000, 12'h000, 16'h2233, 1'b0};
    vecs[18] = '{1'b1, 1'b1, 1'b0, 2'b11, 4'd1,  16'h0000, 16'h0000, 1'b1, 16'hBEEF, 12'h000, 16'h2233, 1'b0};
    vecs[19] = '{1'b1, 1'b0, 1'b1, 2'b11, 4'd1,  16'h0000, 16'h0000, 1'b0, 16'hBEEF, 12'h000, 16'h2233, 1'b0};
    vecs[20] = '{1'b1, 1'b1, 1'b0, 2'b11, 4'd1,  16'h0000, 16'h0000, 1'b1, 16'hBEEF, 12'h000, 16'h2233, 1'b0};
    vecs[21] = '{1'b1, 1'b1, 1'b1, 2'b11, 4'd3,  16'h0000, 16'h0000, 1'b1, 16'hFFCD, 12'h000, 16'h2233, 1'b0};
    vecs[22] = '{1'b1, 1'b1, 1'b0, 2'b11, 4'd3,  16'h0000, 16'h0000, 1'b1, 16'hFFCD, 12'h000, 16'h2233, 1'b0};
    vecs[23] = '{1'b1, 1'b0, 1'b1, 2'b11, 4'd12, 16'h5555, 16'h0000, 1'b0, 16'hFFCD, 12'h000, 16'h2233, 1'b0};
    vecs[24] = '{1'b1, 1'b1, 1'b0, 2'b11, 4'd12, 16'h0000, 16'h0000, 1'b1, 16'h0000, 12'h000, 16'h2233, 1'b0};
    vecs[25] = '{1'b1, 1'b1, 1'b0, 2'b11, 4'd2,  16'h0000, 16'h0000, 1'b1, 16'h1234, 12'h000, 16'h2233, 1'b0};
    vecs[26] = '{1'b0, 1'b1, 1'b0, 2'b11, 4'd3,  16'h0000, 16'h0000, 1'b0, 16'h1234, 12'h000, 16'h2233, 1'b0};
    vecs[27] = '{1'b1, 1'b1, 1'b1, 2'b11, 4'd7,  16'h9999, 16'h0000, 1'b1, 16'h0000, 12'h000, 16'h2233, 1'b0};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst data_out", 32'(data_out), 32'h0);
    check("rst rd_valid", 32'(rd_valid), 32'h0);
    check("rst irq", 32'(irq), 32'h0);
    check("rst strobe", 32'(write_strobe), 32'h0);
    check("rst pulse_data", 32'(pulse_data), 32'h0);
    check("rst reg2", 32'(vo(2)), 32'h1234);
    check("rst reg3", 32'(vo(3)), 32'h1200);
    reset = 1'b0;

    // Table: drive one cycle, check outputs just after the edge.
    for (int v = 0; v < 28; v++) begin
      en = vecs[v].en; rd = vecs[v].rd; wr = vecs[v].wr; be = vecs[v].be;
      addr = vecs[v].addr; data_in = vecs[v].din;
      set_in = (NR*DW)'(vecs[v].set5) << (5*DW);
      @(posedge clk);
      #1;
      idle();
      set_in = '0;
      check($sformatf("v%0d rd_valid", v), 32'(rd_valid), 32'(vecs[v].e_valid));
      check($sformatf("v%0d data_out", v), 32'(data_out), 32'(vecs[v].e_dout));
      check($sformatf("v%0d strobe", v), 32'(write_strobe), 32'(vecs[v].e_strobe));
      check($sformatf("v%0d pulse_data", v), 32'(pulse_data), 32'(vecs[v].e_pdata));
      check($sformatf("v%0d irq", v), 32'(irq), 32'(vecs[v].e_irq));
    end

    check("vo reg3", 32'(vo(3)), 32'hFFCD);
    check("vo reg0", 32'(vo(0)), 32'h0000);
    check("vo reg1 ro", 32'(vo(1)), 32'h0000);
    check("vo reg7 pulse", 32'(vo(7)), 32'h0000);
    check("vo reg5", 32'(vo(5)), 32'h0000);

    // set_in on an RW register has no effect.
    set_in = (NR*DW)'(16'hFFFF) << (2*DW);
    @(posedge clk);
    #1;
    set_in = '0;
    check("set on rw reg2", 32'(vo(2)), 32'h1234);
    check("set on rw irq", 32'(irq), 32'h0);

    // Reset arrives while a read is on the bus.
    en = 1'b1; rd = 1'b1; addr = 4'd2;
    #2 reset = 1'b1;
    #1;
    check("midrd async dout", 32'(data_out), 32'h0);
    @(posedge clk);
    #1;
    idle();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check($sformatf("midrd c%0d rd_valid", c), 32'(rd_valid), 32'h0);
      @(posedge clk);
      #1;
    end
    check("midrd reg3 restored", 32'(vo(3)), 32'h1200);

    // Reset arrives while a pulse write is on the bus.
    en = 1'b1; wr = 1'b1; addr = 4'd7; be = 2'b11; data_in = 16'h00AA;
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    idle();
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      check($sformatf("midwr c%0d strobe", c), 32'(write_strobe), 32'h0);
      check($sformatf("midwr c%0d pdata", c), 32'(pulse_data), 32'h0);
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cc_register_bank.md
Name: cc_register_bank

Overview:
- Synchronous, parametrised successor to the ChronoCube control register file.
- Presents NUM_REGS registers of DATA_WIDTH bits to the host memory bus.
- Per-register type is set by parameter masks: read/write, read-only, write-1-to-clear status, or write-pulse command.
- Status registers aggregate into a registered interrupt output for the host; everything is clocked by the system clock, not the bus strobes.

Parameters:
ADDR_WIDTH, 4, width of register address bus
DATA_WIDTH, 16, register/bus width; multiple of 8
NUM_REGS, 16, number of registers; at most 2**ADDR_WIDTH
RW_MASK, all ones, bit i set: register i is read/write
W1C_MASK, 0, bit i set: register i is write-1-to-clear status (overrides RW)
PULSE_MASK, 0, bit i set: register i is write-pulse command (overrides RW and W1C)
RESET_VALUES, 0, NUM_REGS*DATA_WIDTH reset image for RW registers

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
en  in  1  bus access enable
rd  in  1  read request (valid with en)
wr  in  1  write request (valid with en)
be  in  DATA_WIDTH/8  byte enables, bit k covers data_in[8k+7:8k]
addr  in  ADDR_WIDTH  register address
data_in  in  DATA_WIDTH  write data
data_out  out  DATA_WIDTH  registered read data
rd_valid  out  1  data_out valid this cycle
values_in  in  NUM_REGS*DATA_WIDTH  read values for read-only registers
set_in  in  NUM_REGS*DATA_WIDTH  per-bit set events for W1C registers
values_out  out  NUM_REGS*DATA_WIDTH  current contents of RW and W1C registers
write_strobe  out  NUM_REGS  one-cycle pulse per pulse-register write
pulse_data  out  DATA_WIDTH  byte-masked data of latest pulse write
irq  out  1  OR of all W1C register bits, registered

Behaviour:
- Reset (async, active high):
  - RW registers load RESET_VALUES; W1C registers clear to 0.
  - data_out, rd_valid, write_strobe, pulse_data and irq all go to 0.
- Bus access is sampled on rising clk.
  - Write: en&wr&~rd.
  - Read: en&rd. rd takes priority; if en&rd&wr, the write is dropped.
- Read latency is 1 cycle.
  - data_out is updated on the cycle after the request and holds until the next read.
  - rd_valid is high for exactly that one cycle.
- Read sources by register type:
  - RW and W1C: stored value.
  - Read-only (no mask bit set): values_in slice.
  - Pulse: always 0.
  - addr >= NUM_REGS: 0, with rd_valid still asserted.
- RW write: byte k is updated only if be[k]=1; other bytes are held. Writes to read-only registers or to addr >= NUM_REGS are ignored.
- W1C register, per bit, per cycle: next = (cur & ~clr) | set.
  - clr = data_in bit AND its be bit AND a write to this register.
  - set = set_in bit.
  - A set event in the same cycle as a clear wins; the bit stays 1.
  - set_in is ignored for non-W1C registers.
- Pulse register write:
  - write_strobe[i] goes high for exactly one cycle, the cycle after the write.
  - pulse_data captures data_in & byte-mask in that same cycle and holds until the next pulse write.
  - Back-to-back writes give back-to-back strobes.
- irq = registered OR of all W1C bits. It rises 1 cycle after a set and falls 1 cycle after the last bit clears.
- Reset asserted mid-access: the access is abandoned, and after deassertion no rd_valid or strobe from that access appears.
- values_out slices for RO and pulse registers are 0.

Test Plan:
- Reset with RESET_VALUES reg2=0x1234 -> read addr 2 returns data_out=0x1234 one cycle later with rd_valid=1 for 1 cycle; irq=0.
- Write 0xABCD to RW reg 3 with be=2'b01, then read -> 0x12CD if prior value was 0x1200; be=2'b10 write 0xFF00 -> 0xFFCD.
- W1C reg 5: set_in bit0 pulse -> irq=1 next cycle; write 0x0001 while set_in bit0=1 -> bit stays 1; write 0x0001 alone -> reads 0, irq drops next cycle.
- Pulse reg 7: write 0x0042 -> write_strobe[7]=1 for one cycle, pulse_data=0x0042, readback=0; two consecutive writes -> two consecutive strobes.
- Read-only reg 1 driven values_in=0xBEEF -> readback 0xBEEF; write 0x0000 to it -> still 0xBEEF.
- Simultaneous en&rd&wr to RW reg 3 -> returns old value, register unchanged; addr=NUM_REGS read -> 0, write ignored; reset asserted mid-read -> no rd_valid after release.
